// File: rtl/adder_shift_mult_seq.sv
// Shift-and-add unsigned multiplier sequencer built on a single N-bit adder.
// One add/shift step per clock for N steps, then a one-cycle done pulse.

// N-bit adder with carry in/out; the only arithmetic in the sequencer.
module adder_nbits #(
    parameter int unsigned NUMBER_OF_BITS = 8
) (
    input  logic [NUMBER_OF_BITS-1:0] a,
    input  logic [NUMBER_OF_BITS-1:0] b,
    input  logic                      c_in,
    output logic [NUMBER_OF_BITS-1:0] s_out,
    output logic                      c_out
);

    localparam int unsigned SW = NUMBER_OF_BITS + 1;

    // Full-width sum; the extra bit is the carry out.
    always_comb begin
        {c_out, s_out} = SW'(a) + SW'(b) + SW'(c_in);
    end

endmodule

module adder_shift_mult_seq #(
    parameter int unsigned NUMBER_OF_BITS = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [NUMBER_OF_BITS-1:0]     multiplicand,
    input  logic [NUMBER_OF_BITS-1:0]     multiplier,
    output logic                          busy,
    output logic                          done,
    output logic [2*NUMBER_OF_BITS-1:0]   product
);

    localparam int unsigned N  = NUMBER_OF_BITS;
    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nx;
    logic [N-1:0]    m_r;
    logic [N-1:0]    a_r;
    logic [N-1:0]    q_r;
    logic [CW-1:0]   cnt_r;

    logic [N-1:0]    addend_c;
    logic [N-1:0]    sum_c;
    logic            carry_c;
    logic            last_step_c;

    // Partial product term: M when the current multiplier LSB is set.
    always_comb begin
        addend_c    = q_r[0] ? m_r : '0;
        last_step_c = (cnt_r == CW'(N - 1));
    end

    adder_nbits #(
        .NUMBER_OF_BITS(N)
    ) u_adder (
        .a     (a_r),
        .b     (addend_c),
        .c_in  (1'b0),
        .s_out (sum_c),
        .c_out (carry_c)
    );

    // State register; reset aborts any operation in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state logic: start only matters in IDLE, DONE lasts one cycle.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last_step_c) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture and add/shift datapath; registers hold outside RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_r   <= '0;
            a_r   <= '0;
            q_r   <= '0;
            cnt_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        m_r   <= multiplicand;
                        q_r   <= multiplier;
                        a_r   <= '0;
                        cnt_r <= '0;
                    end
                end
                RUN: begin
                    {a_r, q_r} <= {carry_c, sum_c, q_r[N-1:1]};
                    cnt_r      <= cnt_r + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Status and result are straight decodes of the registers.
    always_comb begin
        busy    = (state_r == RUN);
        done    = (state_r == DONE);
        product = {a_r, q_r};
    end

endmodule

// File: tb/tb_adder_shift_mult_seq.sv
// Self-checking bench for adder_shift_mult_seq against an arithmetic reference.
module tb_adder_shift_mult_seq;

    localparam int unsigned N  = 8;
    localparam int unsigned PW = 2 * N;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [N-1:0]  multiplicand;
    logic [N-1:0]  multiplier;
    logic          busy;
    logic          done;
    logic [PW-1:0] product;

    int n_cmp = 0;
    int n_err = 0;

    adder_shift_mult_seq #(
        .NUMBER_OF_BITS(N)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PW-1:0] ref_mul(input logic [N-1:0] m, input logic [N-1:0] q);
        return PW'(m) * PW'(q);
    endfunction

    // Issue one operation and observe it until well after it completes.
    task automatic do_mult(input logic [N-1:0] m, input logic [N-1:0] q, input bit noise,
                           output logic [PW-1:0] p, output int lat,
                           output int busy_n, output int done_n);
        p            = 'x;
        lat          = -1;
        busy_n       = 0;
        done_n       = 0;
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= int'(N) + 6; c++) begin
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (lat < 0) begin
                    lat = c;
                    p   = product;
                end
            end
            if (noise && c <= int'(N) + 1) begin
                start        = 1'($urandom);
                multiplicand = N'($urandom);
                multiplier   = N'($urandom);
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        start        = 1'b1;
        multiplicand = 8'h5A;
        multiplier   = 8'hA5;
        step();
        step();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (product !== '0) begin n_err++; $display("FAIL reset_product: got %h want 0", product); end
        rst   = 1'b0;
        start = 1'b0;
        step();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_no_accept: busy got %b want 0", busy); end
        n_cmp++; if (product !== '0) begin n_err++; $display("FAIL reset_hold: product got %h want 0", product); end
    endtask

    task automatic test_basic();
        logic [PW-1:0] p;
        int lat, bn, dn;
        do_mult(8'd13, 8'd11, 1'b0, p, lat, bn, dn);
        n_cmp++; if (p !== 16'd143) begin n_err++; $display("FAIL basic_product: got %0d want 143", p); end
        n_cmp++; if (lat != int'(N) + 1) begin n_err++; $display("FAIL basic_latency: got %0d want %0d", lat, N + 1); end
        n_cmp++; if (bn != int'(N)) begin n_err++; $display("FAIL basic_busy_cycles: got %0d want %0d", bn, N); end
        n_cmp++; if (dn != 1) begin n_err++; $display("FAIL basic_done_count: got %0d want 1", dn); end
        n_cmp++; if (product !== 16'd143) begin n_err++; $display("FAIL basic_hold_idle: got %0d want 143", product); end
    endtask

    task automatic test_boundaries();
        logic [N-1:0]  ms [4] = '{8'hFF, 8'h00, 8'hFF, 8'h01};
        logic [N-1:0]  qs [4] = '{8'hFF, 8'hFF, 8'h00, 8'h80};
        logic [PW-1:0] ex [4] = '{16'hFE01, 16'h0000, 16'h0000, 16'h0080};
        logic [PW-1:0] p;
        int lat, bn, dn;
        for (int i = 0; i < 4; i++) begin
            do_mult(ms[i], qs[i], 1'b0, p, lat, bn, dn);
            n_cmp++;
            if (p !== ex[i]) begin
                n_err++;
                $display("FAIL boundary_%0d: %h*%h got %h want %h", i, ms[i], qs[i], p, ex[i]);
            end
        end
    endtask

    task automatic test_random_ops();
        logic [PW-1:0] p;
        logic [N-1:0]  m, q;
        int lat, bn, dn;
        for (int i = 0; i < 8; i++) begin
            m = N'($urandom);
            q = N'($urandom);
            do_mult(m, q, 1'b0, p, lat, bn, dn);
            n_cmp++;
            if (p !== ref_mul(m, q) || lat != int'(N) + 1) begin
                n_err++;
                $display("FAIL random_op_%0d: %h*%h got %h lat %0d want %h lat %0d",
                         i, m, q, p, lat, ref_mul(m, q), N + 1);
            end
        end
    endtask

    task automatic test_ignore_during_run();
        logic [PW-1:0] p;
        logic [N-1:0]  m, q;
        int lat, bn, dn;
        for (int i = 0; i < 3; i++) begin
            m = N'($urandom);
            q = N'($urandom);
            do_mult(m, q, 1'b1, p, lat, bn, dn);
            n_cmp++;
            if (p !== ref_mul(m, q)) begin
                n_err++;
                $display("FAIL noise_product_%0d: got %h want %h", i, p, ref_mul(m, q));
            end
            n_cmp++;
            if (dn != 1 || bn != int'(N)) begin
                n_err++;
                $display("FAIL noise_pulses_%0d: done %0d busy %0d want 1 and %0d", i, dn, bn, N);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [PW-1:0] p;
        logic [N-1:0]  m, q;
        int lat, bn, dn;
        int saw_done;
        multiplicand = 8'hC3;
        multiplier   = 8'h7B;
        start        = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL midrst_running: busy got %b want 1", busy); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy); end
        n_cmp++; if (product !== '0) begin n_err++; $display("FAIL midrst_product: got %h want 0", product); end
        saw_done = 0;
        for (int c = 0; c < int'(N) + 4; c++) begin
            if (done) saw_done++;
            step();
        end
        n_cmp++; if (saw_done != 0) begin n_err++; $display("FAIL midrst_no_done: got %0d pulses want 0", saw_done); end
        m = N'($urandom);
        q = N'($urandom);
        do_mult(m, q, 1'b0, p, lat, bn, dn);
        n_cmp++; if (p !== ref_mul(m, q)) begin n_err++; $display("FAIL midrst_fresh: got %h want %h", p, ref_mul(m, q)); end
    endtask

    task automatic test_start_held();
        logic [PW-1:0] exp_q [$];
        logic [PW-1:0] ex;
        int accepted  = 0;
        int dones     = 0;
        int last_done = -1;
        start        = 1'b1;
        multiplicand = N'($urandom);
        multiplier   = N'($urandom);
        for (int cyc = 0; cyc < 100 * int'(N + 2) + int'(N) + 6; cyc++) begin
            if (start && (cyc % int'(N + 2)) == 0) begin
                exp_q.push_back(ref_mul(multiplicand, multiplier));
                accepted++;
            end
            step();
            if (accepted == 100) start = 1'b0;
            multiplicand = N'($urandom);
            multiplier   = N'($urandom);
            if (done) begin
                dones++;
                ex = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                n_cmp++;
                if (product !== ex) begin
                    n_err++;
                    $display("FAIL held_product_%0d: got %h want %h", dones, product, ex);
                end
                if (last_done >= 0) begin
                    n_cmp++;
                    if (cyc - last_done != int'(N + 2)) begin
                        n_err++;
                        $display("FAIL held_spacing_%0d: got %0d want %0d", dones, cyc - last_done, N + 2);
                    end
                end
                last_done = cyc;
            end
        end
        start = 1'b0;
        n_cmp++; if (dones != 100) begin n_err++; $display("FAIL held_done_count: got %0d want 100", dones); end
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        test_reset();
        test_basic();
        test_boundaries();
        test_random_ops();
        test_ignore_during_run();
        test_mid_reset();
        test_start_held();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
